alarm_trigger: RTL
==================

// Module: alarm_trigger
// PURPOSE
//  Downstream consumer of the time/date counter. Compares the running time against the
//  stored alarm time and, on a match, drives a gated buzzer. Supports snooze (bounded
//  count), stop, and ring timeout. Feeds the buzzer pin and the display status LEDs.
// PARAMETERS
//  CLK_PER_SEC   1000  CLK cycles per second (1 kHz system clock)
//  BEEP_HALF     1     CLK cycles per buzzer half-period (tone = CLK/(2*BEEP_HALF))
//  GATE_HALF     500   CLK cycles per beep on/off gate half-period
//  RING_SEC      60    seconds of ringing before auto-stop
//  SNOOZE_SEC    300   seconds spent in snooze before re-ringing
//  SNOOZE_MAX    3     snoozes allowed per alarm event
// PORTS
//  CLK           in   1   system clock
//  RESETN        in   1   asynchronous active-low reset
//  CUR_TIME      in   18  {MERIDIAN,HOUR[16:12],MIN[11:6],SEC[5:0]}, 24 h HOUR
//  ALARM_TIME    in   17  {HOUR[16:12],MIN[11:6],SEC[5:0]}
//  ALARM_EN      in   1   level; 0 disarms and forces IDLE
//  SNOOZE_KEY    in   1   level, synchronous to CLK; rising edge = request
//  STOP_KEY      in   1   level, synchronous to CLK; rising edge = request
//  BUZZER        out  1   gated square wave to piezo
//  RINGING       out  1   1 while in RING
//  SNOOZING      out  1   1 while in SNOOZE
//  SNOOZE_LEFT   out  2   remaining snoozes for current event
// BEHAVIOUR
//  Reset (async, RESETN=0): state IDLE; all outputs 0 except SNOOZE_LEFT=SNOOZE_MAX;
//   internal counters, key history and previous-second register cleared.
//  Second tick: sec_tick=1 for one cycle when CUR_TIME[5:0] differs from its registered
//   value from the previous cycle. All second-based timers advance only on sec_tick.
//  Match: ALARM_EN && CUR_TIME[16:0]==ALARM_TIME && sec_tick. MERIDIAN is ignored.
//   Match fires once per matching second; a time held constant never re-fires.
//  Keys: rising-edge detected with 1 registered stage; action on the cycle after the edge.
//  FSM (3 states):
//   IDLE   -> RING on match; load ring_cnt=RING_SEC, SNOOZE_LEFT=SNOOZE_MAX.
//   RING   -> IDLE on STOP edge; -> SNOOZE on SNOOZE edge if SNOOZE_LEFT>0
//             (SNOOZE_LEFT-=1, snz_cnt=SNOOZE_SEC); SNOOZE edge ignored if SNOOZE_LEFT==0;
//             ring_cnt-=1 per sec_tick; -> IDLE when ring_cnt reaches 0.
//   SNOOZE -> IDLE on STOP edge; snz_cnt-=1 per sec_tick; at 0 -> RING, ring_cnt=RING_SEC.
//  Priority per cycle: ALARM_EN=0 > STOP > SNOOZE > timer expiry > match.
//   STOP and SNOOZE edges in same cycle: STOP wins. Match while in RING/SNOOZE: ignored.
//  ALARM_EN falling in any state: IDLE next cycle, BUZZER=0 same edge.
//  Outputs registered: RINGING/SNOOZING change on the clock edge that changes state
//   (match at edge N -> RINGING=1 after edge N+1, since sec_tick is registered).
//  BUZZER = tone & gate & RINGING; tone toggles every BEEP_HALF cycles, gate toggles
//   every GATE_HALF cycles; both restart (gate=1, tone=1) on entry to RING.
//  Counters: ring_cnt, snz_cnt wide enough for parameter maxima (>= clog2+1), no wrap;
//   decrement saturates at 0. SNOOZE_LEFT holds after event ends until next match.
//  Time jump (SETTING load upstream) makes sec_tick fire; match still requires equality.
// STRUCTURE
//  Shared package/header: state encodings (ST_IDLE=0, ST_RING=1, ST_SNOOZE=2), time-field
//   bit slice defines (HOUR/MIN/SEC/MERIDIAN positions) common with the time counter.
//  One sub-module: key_edge (level in -> 1-cycle rising-edge pulse), instanced twice.
//  Remainder: sec_tick detect, FSM, two second counters, tone/gate dividers in top.
// TESTING
//  1 Reset mid-RING: RESETN=0 async -> BUZZER,RINGING=0 immediately, SNOOZE_LEFT=3.
//  2 ALARM_TIME=07:30:00, step CUR_TIME 07:29:59->07:30:00 -> RINGING=1 two edges later;
//    hold 07:30:00 200 cycles -> single trigger only; BUZZER gate period 1000 cycles.
//  3 Ring, no keys, 60 sec ticks -> RINGING=0 after 60th tick, state IDLE.
//  4 Ring, SNOOZE x3 (each after 300 ticks re-ring) -> SNOOZE_LEFT 2,1,0; 4th SNOOZE
//    ignored, RINGING stays 1.
//  5 STOP and SNOOZE rising same cycle in RING -> IDLE, SNOOZE_LEFT unchanged (3).
//  6 ALARM_EN=0 during SNOOZE -> IDLE next edge; match with ALARM_EN=0 -> no RING.

Source files
------------

// File: rtl/alarm_trigger_pkg.sv
// -----------------------------------------------------------------------------
// alarm_trigger_pkg
// Purpose : Shared definitions for the alarm trigger and the time counter that
//           feeds it: FSM state encodings and the bit positions of the fields
//           inside the packed time word.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package alarm_trigger_pkg;

  // Alarm FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  // Packed time word: {MERIDIAN, HOUR[16:12], MIN[11:6], SEC[5:0]}
  localparam int TIME_W       = 18;
  localparam int ALARM_W      = 17;
  localparam int MERIDIAN_BIT = 17;
  localparam int HOUR_MSB     = 16;
  localparam int HOUR_LSB     = 12;
  localparam int MIN_MSB      = 11;
  localparam int MIN_LSB      = 6;
  localparam int SEC_MSB      = 5;
  localparam int SEC_LSB      = 0;

  // Width of a down-counter that must hold max_val without wrapping
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/alarm_trigger_key_edge.sv
// -----------------------------------------------------------------------------
// alarm_trigger_key_edge
// Purpose : Turns a CLK-synchronous key level into a one-cycle pulse on its
//           rising edge, using a single registered history stage.
// Ports   : CLK    in  system clock
//           RESETN in  asynchronous active-low reset
//           KEY    in  key level (already synchronous to CLK)
//           PULSE  out 1 for the cycle in which KEY is high and was low before
// -----------------------------------------------------------------------------
module alarm_trigger_key_edge (
  input  logic CLK,
  input  logic RESETN,
  input  logic KEY,
  output logic PULSE
);

  logic key_d_r;

  // Key history register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      key_d_r <= 1'b0;
    end else begin
      key_d_r <= KEY;
    end
  end

  assign PULSE = KEY & ~key_d_r;

endmodule

// File: rtl/alarm_trigger.sv
// -----------------------------------------------------------------------------
// alarm_trigger
// Purpose : Compares the running time with the stored alarm time and, on a
//           match, rings a gated buzzer. Supports a bounded number of snoozes,
//           a stop key and an automatic stop after a ring timeout.
// Ports   : CLK         in  system clock
//           RESETN      in  asynchronous active-low reset
//           CUR_TIME    in  {MERIDIAN,HOUR,MIN,SEC}, 24 h HOUR
//           ALARM_TIME  in  {HOUR,MIN,SEC}
//           ALARM_EN    in  level; 0 disarms and forces IDLE
//           SNOOZE_KEY  in  level; rising edge requests snooze
//           STOP_KEY    in  level; rising edge requests stop
//           BUZZER      out gated square wave to the piezo
//           RINGING     out 1 while ringing
//           SNOOZING    out 1 while snoozing
//           SNOOZE_LEFT out snoozes remaining for the current alarm event
// -----------------------------------------------------------------------------
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int CLK_PER_SEC = 1000,
  parameter int BEEP_HALF   = 1,
  parameter int GATE_HALF   = 500,
  parameter int RING_SEC    = 60,
  parameter int SNOOZE_SEC  = 300,
  parameter int SNOOZE_MAX  = 3
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic [TIME_W-1:0]  CUR_TIME,
  input  logic [ALARM_W-1:0] ALARM_TIME,
  input  logic               ALARM_EN,
  input  logic               SNOOZE_KEY,
  input  logic               STOP_KEY,
  output logic               BUZZER,
  output logic               RINGING,
  output logic               SNOOZING,
  output logic [1:0]         SNOOZE_LEFT
);

  // A beep gate half-period longer than one second is never useful, so clamp it
  localparam int GATE_LIM = (GATE_HALF < CLK_PER_SEC) ? GATE_HALF : CLK_PER_SEC;
  localparam int RING_W   = cnt_width(RING_SEC);
  localparam int SNZ_W    = cnt_width(SNOOZE_SEC);
  localparam int TONE_W   = cnt_width(BEEP_HALF);
  localparam int GATE_W   = cnt_width(GATE_LIM);

  // ---------------------------------------------------------------------------
  // Second tick and match detection
  // ---------------------------------------------------------------------------
  logic [5:0] sec_prev_r;
  logic       sec_tick_r;
  logic       match_r;
  logic       sec_change_s;
  logic       time_eq_s;
  logic       unused_meridian_s;

  // MERIDIAN is display-only; the match uses the 24 h hour field
  assign unused_meridian_s = CUR_TIME[MERIDIAN_BIT];

  assign sec_change_s = (CUR_TIME[SEC_MSB:SEC_LSB] != sec_prev_r);
  assign time_eq_s    = (CUR_TIME[HOUR_MSB:HOUR_LSB] == ALARM_TIME[HOUR_MSB:HOUR_LSB]) &&
                        (CUR_TIME[MIN_MSB:MIN_LSB]   == ALARM_TIME[MIN_MSB:MIN_LSB])   &&
                        (CUR_TIME[SEC_MSB:SEC_LSB]   == ALARM_TIME[SEC_MSB:SEC_LSB]);

  // Second-change detector; a match only counts on the cycle the second changes,
  // so a time held at the alarm value fires exactly once
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sec_prev_r <= 6'd0;
      sec_tick_r <= 1'b0;
      match_r    <= 1'b0;
    end else begin
      sec_prev_r <= CUR_TIME[SEC_MSB:SEC_LSB];
      sec_tick_r <= sec_change_s;
      match_r    <= sec_change_s & ALARM_EN & time_eq_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Key edge detectors
  // ---------------------------------------------------------------------------
  logic snooze_pulse_s;
  logic stop_pulse_s;

  alarm_trigger_key_edge u_snooze_edge (
    .CLK    (CLK),
    .RESETN (RESETN),
    .KEY    (SNOOZE_KEY),
    .PULSE  (snooze_pulse_s)
  );

  alarm_trigger_key_edge u_stop_edge (
    .CLK    (CLK),
    .RESETN (RESETN),
    .KEY    (STOP_KEY),
    .PULSE  (stop_pulse_s)
  );

  // ---------------------------------------------------------------------------
  // FSM and second counters
  // ---------------------------------------------------------------------------
  state_e            state_r;
  state_e            next_state_s;
  logic [RING_W-1:0] ring_cnt_r;
  logic [RING_W-1:0] ring_cnt_nx_s;
  logic [SNZ_W-1:0]  snz_cnt_r;
  logic [SNZ_W-1:0]  snz_cnt_nx_s;
  logic [1:0]        left_r;
  logic [1:0]        left_nx_s;

  // Next-state logic; priority is disarm > stop > snooze > timer expiry > match
  always_comb begin
    next_state_s  = state_r;
    ring_cnt_nx_s = ring_cnt_r;
    snz_cnt_nx_s  = snz_cnt_r;
    left_nx_s     = left_r;
    if (!ALARM_EN) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Matches are only honoured here; RING/SNOOZE ignore them
          if (match_r) begin
            next_state_s  = ST_RING;
            ring_cnt_nx_s = RING_W'(RING_SEC);
            left_nx_s     = 2'(SNOOZE_MAX);
          end else begin
            next_state_s  = ST_IDLE;
          end
        end
        ST_RING: begin
          if (stop_pulse_s) begin
            next_state_s = ST_IDLE;
          end else if (snooze_pulse_s && (left_r != 2'd0)) begin
            next_state_s = ST_SNOOZE;
            left_nx_s    = left_r - 2'd1;
            snz_cnt_nx_s = SNZ_W'(SNOOZE_SEC);
          end else if (sec_tick_r) begin
            // Saturating decrement; the tick that reaches 0 ends the ring
            ring_cnt_nx_s = (ring_cnt_r == {RING_W{1'b0}}) ? {RING_W{1'b0}}
                                                          : ring_cnt_r - RING_W'(1);
            if (ring_cnt_r <= RING_W'(1)) begin
              next_state_s = ST_IDLE;
            end else begin
              next_state_s = ST_RING;
            end
          end else begin
            next_state_s = ST_RING;
          end
        end
        ST_SNOOZE: begin
          if (stop_pulse_s) begin
            next_state_s = ST_IDLE;
          end else if (sec_tick_r) begin
            snz_cnt_nx_s = (snz_cnt_r == {SNZ_W{1'b0}}) ? {SNZ_W{1'b0}}
                                                       : snz_cnt_r - SNZ_W'(1);
            if (snz_cnt_r <= SNZ_W'(1)) begin
              next_state_s  = ST_RING;
              ring_cnt_nx_s = RING_W'(RING_SEC);
            end else begin
              next_state_s  = ST_SNOOZE;
            end
          end else begin
            next_state_s = ST_SNOOZE;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tone and gate dividers
  // ---------------------------------------------------------------------------
  logic              tone_r;
  logic              gate_r;
  logic [TONE_W-1:0] tone_cnt_r;
  logic [GATE_W-1:0] gate_cnt_r;
  logic              tone_nx_s;
  logic              gate_nx_s;
  logic [TONE_W-1:0] tone_cnt_nx_s;
  logic [GATE_W-1:0] gate_cnt_nx_s;

  // Dividers run only while ringing and restart high on every entry to RING
  always_comb begin
    tone_nx_s     = 1'b0;
    gate_nx_s     = 1'b0;
    tone_cnt_nx_s = {TONE_W{1'b0}};
    gate_cnt_nx_s = {GATE_W{1'b0}};
    if (next_state_s == ST_RING) begin
      if (state_r != ST_RING) begin
        tone_nx_s = 1'b1;
        gate_nx_s = 1'b1;
      end else begin
        if (tone_cnt_r == TONE_W'(BEEP_HALF - 1)) begin
          tone_nx_s     = ~tone_r;
          tone_cnt_nx_s = {TONE_W{1'b0}};
        end else begin
          tone_nx_s     = tone_r;
          tone_cnt_nx_s = tone_cnt_r + TONE_W'(1);
        end
        if (gate_cnt_r == GATE_W'(GATE_LIM - 1)) begin
          gate_nx_s     = ~gate_r;
          gate_cnt_nx_s = {GATE_W{1'b0}};
        end else begin
          gate_nx_s     = gate_r;
          gate_cnt_nx_s = gate_cnt_r + GATE_W'(1);
        end
      end
    end else begin
      tone_nx_s     = 1'b0;
      gate_nx_s     = 1'b0;
      tone_cnt_nx_s = {TONE_W{1'b0}};
      gate_cnt_nx_s = {GATE_W{1'b0}};
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  logic ringing_r;
  logic snoozing_r;
  logic buzzer_r;

  // Outputs are registered from next-state values so they change on the same
  // edge as the state (disarm silences the buzzer on that edge too)
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r    <= ST_IDLE;
      ring_cnt_r <= {RING_W{1'b0}};
      snz_cnt_r  <= {SNZ_W{1'b0}};
      left_r     <= 2'(SNOOZE_MAX);
      tone_r     <= 1'b0;
      gate_r     <= 1'b0;
      tone_cnt_r <= {TONE_W{1'b0}};
      gate_cnt_r <= {GATE_W{1'b0}};
      ringing_r  <= 1'b0;
      snoozing_r <= 1'b0;
      buzzer_r   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      ring_cnt_r <= ring_cnt_nx_s;
      snz_cnt_r  <= snz_cnt_nx_s;
      left_r     <= left_nx_s;
      tone_r     <= tone_nx_s;
      gate_r     <= gate_nx_s;
      tone_cnt_r <= tone_cnt_nx_s;
      gate_cnt_r <= gate_cnt_nx_s;
      ringing_r  <= (next_state_s == ST_RING);
      snoozing_r <= (next_state_s == ST_SNOOZE);
      buzzer_r   <= tone_nx_s & gate_nx_s;
    end
  end

  assign BUZZER      = buzzer_r;
  assign RINGING     = ringing_r;
  assign SNOOZING    = snoozing_r;
  assign SNOOZE_LEFT = left_r;

endmodule
